// File: rtl/decode_out_serializer_if.sv
// Bus between the radix-4 bit-extract stage, the output serializer and its serial consumer.
// Optional o_bit_total is present only when DECODE_OUT_BITCNT_EN is defined.
interface decode_out_serializer_if #(
    parameter int AW = 4
) ();
    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and the payload is held stable while valid & !ready.
    logic          i_nib_valid;
    logic [3:0]    i_nib;
    logic          o_nib_ready;
    logic          o_bit;
    logic          o_bit_valid;
    logic          i_bit_ready;
    logic [AW:0]   o_count;
    logic          o_empty;
    logic          o_full;
    logic          o_overflow;
    logic          dbg_state;
`ifdef DECODE_OUT_BITCNT_EN
    logic [15:0]   o_bit_total;
`endif

    modport master (
        output i_nib_valid,
        output i_nib,
        input  o_nib_ready,
        input  o_bit,
        input  o_bit_valid,
        output i_bit_ready,
        input  o_count,
        input  o_empty,
        input  o_full,
        input  o_overflow,
`ifdef DECODE_OUT_BITCNT_EN
        input  o_bit_total,
`endif
        input  dbg_state
    );

    modport slave (
        input  i_nib_valid,
        input  i_nib,
        output o_nib_ready,
        output o_bit,
        output o_bit_valid,
        input  i_bit_ready,
        output o_count,
        output o_empty,
        output o_full,
        output o_overflow,
`ifdef DECODE_OUT_BITCNT_EN
        output o_bit_total,
`endif
        output dbg_state
    );
endinterface

// File: rtl/decode_out_serializer.sv
// Nibble FIFO plus MSB-first bit serializer for the Viterbi decoder output.
// Define DECODE_OUT_BITCNT_EN to add the 16-bit wrapping o_bit_total handshake counter.
module decode_out_serializer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    decode_out_serializer_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t         state, state_nx;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [3:0]     sh, sh_nx;
    logic [1:0]     bcnt, bcnt_nx;
    logic           overflow;
    logic           empty, full, nib_ready;
    logic           push, pop, hs;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign nib_ready = !full;
    assign push      = bus.i_nib_valid && nib_ready;
    assign hs        = (state == SHIFT) && bus.i_bit_ready;

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        bcnt_nx  = bcnt;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    sh_nx    = mem[rd_ptr];
                    bcnt_nx  = 2'd3;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (hs) begin
                    if (bcnt != 2'd0) begin
                        sh_nx   = {sh[2:0], 1'b0};
                        bcnt_nx = bcnt - 2'd1;
                    end else if (!empty) begin
                        // Reload on the last bit's handshake so nibbles stream without a bubble.
                        pop     = 1'b1;
                        sh_nx   = mem[rd_ptr];
                        bcnt_nx = 2'd3;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.i_nib;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            bcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            bcnt  <= bcnt_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.i_nib_valid && !nib_ready) overflow <= 1'b1;
        end
    end

`ifdef DECODE_OUT_BITCNT_EN
    logic [15:0] bit_total;

    always_ff @(posedge clk) begin
        if (rst)     bit_total <= '0;
        else if (hs) bit_total <= bit_total + 16'd1;
    end

    assign bus.o_bit_total = bit_total;
`endif

    assign bus.o_nib_ready = nib_ready;
    assign bus.o_bit       = (state == SHIFT) && sh[3];
    assign bus.o_bit_valid = (state == SHIFT);
    assign bus.o_count     = count;
    assign bus.o_empty     = empty;
    assign bus.o_full      = full;
    assign bus.o_overflow  = overflow;
    assign bus.dbg_state   = (state == SHIFT);
endmodule

// File: tb/tb_decode_out_serializer.sv
// Self-checking bench for decode_out_serializer: bit scoreboard plus per-scenario tasks.
module tb_decode_out_serializer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [0:0] exp_q[$];

    decode_out_serializer_if #(.AW(4)) bus ();

    decode_out_serializer #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every bit handshake is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.o_bit_valid === 1'b1 && bus.i_bit_ready === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_bit: got bit %0b with nothing expected", bus.o_bit);
            end else begin
                logic [0:0] e;
                e = exp_q.pop_front();
                if (bus.o_bit !== e) begin
                    tests_failed++;
                    $display("FAIL bit_value: got %0b expected %0b", bus.o_bit, e);
                end
            end
        end
    end

    task automatic fail_msg(input string name, input int act, input int req);
        tests_failed++;
        $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic check(input string name, input int act, input int req);
        // Only scalar bookkeeping; each caller passes observed DUT values.
        tests_run++;
        if (act !== req) fail_msg(name, act, req);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_nib(input logic [3:0] n);
        int guard;
        guard = 0;
        while (bus.o_nib_ready !== 1'b1 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) begin
            tests_run++;
            fail_msg("push_timeout", guard, 0);
        end
        bus.i_nib_valid = 1'b1;
        bus.i_nib       = n;
        for (int b = 3; b >= 0; b--) exp_q.push_back(n[b]);
        @(posedge clk); #1;
        bus.i_nib_valid = 1'b0;
    endtask

    task automatic drop_nib(input logic [3:0] n);
        bus.i_nib_valid = 1'b1;
        bus.i_nib       = n;
        @(posedge clk); #1;
        bus.i_nib_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.o_bit_valid !== 1'b0) && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (cyc >= bound) fail_msg("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_nib_valid = 1'b0;
        bus.i_nib       = 4'h0;
        bus.i_bit_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 ||
            bus.o_nib_ready !== 1'b1 || bus.o_overflow !== 1'b0 ||
            bus.o_bit !== 1'b0 || bus.o_bit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: cnt=%0d empty=%0b full=%0b rdy=%0b ovf=%0b bit=%0b vld=%0b, required 0 1 0 1 0 0 0",
                     bus.o_count, bus.o_empty, bus.o_full, bus.o_nib_ready,
                     bus.o_overflow, bus.o_bit, bus.o_bit_valid);
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_single_nibble();
        bus.i_bit_ready = 1'b1;
        push_nib(4'hA);
        check("latency_edge_n", int'(bus.o_bit_valid), 0);
        @(posedge clk); #1;
        check("latency_edge_n1", int'(bus.o_bit_valid), 1);
        check("first_bit_msb", int'(bus.o_bit), 1);
        wait_drain(20);
        check("single_empty", int'(bus.o_empty), 1);
        check("single_valid_low", int'(bus.o_bit_valid), 0);
    endtask

    task automatic test_back_to_back();
        int gaps;
        bus.i_bit_ready = 1'b1;
        push_nib(4'h3);
        push_nib(4'hC);
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_bit_valid !== 1'b1) gaps++;
            @(posedge clk); #1;
        end
        check("b2b_no_bubble", gaps, 0);
        check("b2b_valid_after", int'(bus.o_bit_valid), 0);
        wait_drain(20);
    endtask

    task automatic test_fill_overflow();
        bus.i_bit_ready = 1'b0;
        // The first nibble moves straight into the shift register, so 17 accepted pushes fill 16 slots.
        for (int i = 0; i < 16; i++) push_nib(4'(i));
        check("count_after_16", int'(bus.o_count), 15);
        push_nib(4'h5);
        check("full_flag", int'(bus.o_full), 1);
        check("full_count", int'(bus.o_count), 16);
        check("full_ready_low", int'(bus.o_nib_ready), 0);
        check("no_overflow_yet", int'(bus.o_overflow), 0);
        drop_nib(4'hE);
        check("overflow_set", int'(bus.o_overflow), 1);
        check("count_after_drop", int'(bus.o_count), 16);
        bus.i_bit_ready = 1'b1;
        wait_drain(200);
        check("overflow_sticky", int'(bus.o_overflow), 1);
        check("drain_empty", int'(bus.o_empty), 1);
    endtask

    task automatic test_wrap_toggle();
        int cyc;
        logic r, prev_bit, prev_valid;
        bus.i_bit_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push_nib(4'(i));
        check("toggle_fill_count", int'(bus.o_count), 15);
        cyc = 0;
        while ((exp_q.size() != 0 || bus.o_bit_valid !== 1'b0) && cyc < 300) begin
            r = cyc[0] ? 1'b0 : 1'b1;
            bus.i_bit_ready = r;
            prev_bit   = bus.o_bit;
            prev_valid = bus.o_bit_valid;
            @(posedge clk); #1;
            if (!r && prev_valid) begin
                tests_run++;
                if (bus.o_bit !== prev_bit || bus.o_bit_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL hold_stable: got bit=%0b vld=%0b expected bit=%0b vld=1",
                             bus.o_bit, bus.o_bit_valid, prev_bit);
                end
            end
            cyc++;
        end
        tests_run++;
        if (cyc >= 300) fail_msg("toggle_timeout", exp_q.size(), 0);
        bus.i_bit_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_nib(4'($urandom_range(0, 15)));
        wait_drain(100);
        check("wrap_refill_empty", int'(bus.o_empty), 1);
    endtask

    task automatic test_reset_midstream();
        check("ovf_before_rst", int'(bus.o_overflow), 1);
        bus.i_bit_ready = 1'b1;
        push_nib(4'h9);
        @(posedge clk); #1;
        check("mid_first_bit", int'(bus.o_bit), 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", int'(bus.o_bit_valid), 0);
        check("mid_rst_count", int'(bus.o_count), 0);
        check("mid_rst_overflow", int'(bus.o_overflow), 0);
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 10; i++) begin
                if (bus.o_bit_valid !== 1'b0) stray++;
                @(posedge clk); #1;
            end
            check("no_residual_bits", stray, 0);
        end
    endtask

`ifdef DECODE_OUT_BITCNT_EN
    task automatic test_bit_total();
        apply_reset();
        check("total_after_rst", int'(bus.o_bit_total), 0);
        bus.i_bit_ready = 1'b1;
        // 16385 nibbles = 65540 bits, which wraps the 16-bit counter to 4.
        for (int i = 0; i < 16385; i++) push_nib(4'($urandom_range(0, 15)));
        wait_drain(200);
        check("total_wrap", int'(bus.o_bit_total), 4);
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_nibble();
        test_back_to_back();
        test_fill_overflow();
        test_wrap_toggle();
        test_reset_midstream();
`ifdef DECODE_OUT_BITCNT_EN
        test_bit_total();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
